skin_ellipse_classifier: RTL
============================

// Module: skin_ellipse_classifier
// PURPOSE
//  Downstream of the Cb/Cr nonlinear transform stages. Takes transformed chroma Cb', Cr'
//  (signed 32-bit, Q18.14) with a valid strobe and frame markers, then applies the
//  rotated-ellipse skin test in a 6-stage pipeline. Emits a 1-bit skin mask per pixel
//  and per-frame pixel/skin counts for the face-locator stage.
// PARAMETERS
//  CNT_W    20  width of frame pixel/skin counters; counters saturate at 2^CNT_W-1
//  LATENCY  6   pipeline depth; fixed, not user-tunable (documents the 6 stages)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   Cb'/Cr'/sof/eof valid this cycle
//  cb_t        in   32  transformed Cb', signed Q18.14
//  cr_t        in   32  transformed Cr', signed Q18.14
//  sof_in      in   1   first pixel of frame; qualified by in_valid
//  eof_in      in   1   last pixel of frame; qualified by in_valid
//  out_valid   out  1   skin_out valid (in_valid delayed 6)
//  skin_out    out  1   1 = pixel inside skin ellipse
//  frame_pix   out  CNT_W  valid pixels in last completed frame
//  frame_skin  out  CNT_W  skin pixels in last completed frame
//  stats_valid out  1   one-cycle pulse when frame_pix/frame_skin update
// BEHAVIOUR
//  Reset: all pipeline regs, out_valid, skin_out, counters, frame_pix, frame_skin and
//   stats_valid go to 0 immediately; in-flight pixels are discarded, not flushed.
//  No backpressure; in_valid may be asserted every cycle. Bubbles pass through unchanged.
//  Data regs load only when their stage valid is 1; valid/sof/eof shift every cycle.
//  Arithmetic (all signed, two's complement):
//   S1: dcb = (cb_t>>>8) - CX; dcr = (cr_t>>>8) - CY  (Q6, 24 bit)
//   S2: pxa = COS*dcb; pxb = SIN*dcr; pya = -SIN*dcb; pyb = COS*dcr  (Q20, 40 bit)
//   S3: ex = ((pxa+pxb)>>>14) - ECX; ey = ((pya+pyb)>>>14) - ECY  (Q6, 26 bit)
//   S4: ex2 = ex*ex; ey2 = ey*ey  (Q12, unsigned, 52 bit)
//   S5: ta = ex2*IA2; tb = ey2*IB2  (Q32, 64 bit unsigned, no overflow for 26-bit ex/ey)
//   S6: skin_out = (ta + tb) <= ONE_Q32; the sum is 65 bit, so the comparison is exact.
//  Constants (Q14 trig, Q6 offsets, Q20 inverse squares):
//   COS=-13414, SIN=9408, CX=7000, CY=9729, ECX=102, ECY=154, IA2=1626, IB2=5327,
//   ONE_Q32=2^32.
//  Frame stats at output stage (pixel with out_valid=1):
//   sof: pix_cnt<=1, skin_cnt<=skin_out (the pixel starts the new frame).
//   otherwise: pix_cnt+1 and skin_cnt+skin_out, each saturating at 2^CNT_W-1.
//   eof: frame_pix/frame_skin <= counts including this pixel; next cycle stats_valid=1.
//   sof and eof on the same pixel: one-pixel frame, frame_pix=1.
//   eof without prior sof: counts continue from the current value (no error flag).
//   sof/eof are ignored when the associated valid is 0.
// STRUCTURE
//  Package skin_pkg: fixed-point constants above, CNT_W default, Q-format localparams.
//  One sub-module: skin_mult_pipe, a registered signed multiplier (1-cycle) reused for
//   S2, S4 and S5; the rest stays inline. Pipeline valid is a 1-bit x 6 shift chain.
// TESTING
//  cb_t=109<<14, cr_t=152<<14, in_valid=1 -> 6 cycles later out_valid=1, skin_out=1.
//  cb_t=200<<14, cr_t=100<<14 -> skin_out=0; cb_t=cr_t=0 and cb_t=cr_t=255<<14 -> 0.
//  Back-to-back 8 pixels, alternating skin/non-skin, with 2-cycle bubble -> mask
//   pattern and bubble reproduced exactly 6 cycles later.
//  Frame of 100 valid pixels (40 skin), sof on first, eof on last -> frame_pix=100,
//   frame_skin=40, stats_valid one pulse; next frame counts restart from 1.
//  rst asserted mid-frame with pixels in flight -> all outputs 0 that cycle;
//   no out_valid after release until new input arrives 6 cycles later.
//  CNT_W=4, 20-pixel all-skin frame -> frame_pix=15, frame_skin=15 (saturated).

Source files
------------

// File: rtl/skin_pkg.sv
// Fixed-point constants and widths for the rotated-ellipse skin classifier.
// Trig in Q14, offsets in Q6, inverse squared semi-axes in Q20.
package skin_pkg;

  localparam int CNT_W_DEF = 20;
  localparam int LATENCY   = 6;

  localparam int IN_W  = 32;
  localparam int D_W   = 24;
  localparam int K_W   = 16;
  localparam int P2_W  = D_W + K_W;
  localparam int S3_W  = P2_W + 1;
  localparam int E_W   = 26;
  localparam int SQ_W  = 2 * E_W;
  localparam int T5A_W = SQ_W + 1;
  localparam int P5_W  = T5A_W + K_W;
  localparam int SUM_W = P5_W + 1;
  localparam int Q_SH  = 14;

  localparam logic signed [K_W-1:0] COS  = -16'sd13414;
  localparam logic signed [K_W-1:0] SIN  = 16'sd9408;
  localparam logic signed [K_W-1:0] NSIN = -16'sd9408;
  localparam logic signed [K_W-1:0] IA2  = 16'sd1626;
  localparam logic signed [K_W-1:0] IB2  = 16'sd5327;

  localparam logic signed [IN_W-1:0] CX = 32'sd7000;
  localparam logic signed [IN_W-1:0] CY = 32'sd9729;

  localparam logic signed [S3_W-1:0] ECX = 41'sd102;
  localparam logic signed [S3_W-1:0] ECY = 41'sd154;

  localparam logic signed [SUM_W-1:0] ONE_Q32 =
    70'sd4294967296;

  typedef struct packed {
    logic signed [D_W-1:0] dcb;
    logic signed [D_W-1:0] dcr;
  } s1_t;

  typedef struct packed {
    logic signed [E_W-1:0] ex;
    logic signed [E_W-1:0] ey;
  } s3_t;

endpackage

// File: rtl/skin_mult_pipe.sv
// Registered signed multiplier, one cycle of latency.
// Product register loads only when the stage feeding it is valid.
module skin_mult_pipe #(
  parameter int AW = 16,
  parameter int BW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [AW-1:0]     a,
  input  logic signed [BW-1:0]     b,
  output logic signed [AW+BW-1:0]  p
);

  localparam int PW = AW + BW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/skin_ellipse_classifier.sv
// Six-stage rotated-ellipse skin test on transformed chroma,
// with per-frame pixel and skin counters at the output stage.
module skin_ellipse_classifier
  import skin_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] cb_t,
  input  logic signed [IN_W-1:0] cr_t,
  input  logic                   sof_in,
  input  logic                   eof_in,
  output logic                   out_valid,
  output logic                   skin_out,
  output logic [CNT_W-1:0]       frame_pix,
  output logic [CNT_W-1:0]       frame_skin,
  output logic                   stats_valid
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] sof_p;
  logic [LATENCY-1:0] eof_p;

  s1_t s1;
  s3_t s3;

  logic signed [P2_W-1:0]  pxa, pxb, pya, pyb;
  logic signed [S3_W-1:0]  sx, sy;
  logic signed [SQ_W-1:0]  ex2, ey2;
  logic signed [P5_W-1:0]  ta, tb;
  logic signed [SUM_W-1:0] tsum;

  logic [CNT_W-1:0] pix_cnt, skin_cnt;
  logic [CNT_W-1:0] pix_nx, skin_nx;

  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      sof_p <= '0;
      eof_p <= '0;
    end else begin
      vld   <= {vld[LATENCY-2:0], in_valid};
      sof_p <= {sof_p[LATENCY-2:0], in_valid & sof_in};
      eof_p <= {eof_p[LATENCY-2:0], in_valid & eof_in};
    end
  end

  assign out_valid = vld[LATENCY-1];

  // S1: drop to Q6 and centre on the chroma origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (in_valid) begin
      s1.dcb <= D_W'((cb_t >>> 8) - CX);
      s1.dcr <= D_W'((cr_t >>> 8) - CY);
    end
  end

  // S2: rotation products
  skin_mult_pipe #(.AW(D_W), .BW(K_W)) u_pxa (
    .clk(clk), .rst(rst), .en(vld[0]),
    .a(s1.dcb), .b(COS), .p(pxa)
  );

  skin_mult_pipe #(.AW(D_W), .BW(K_W)) u_pxb (
    .clk(clk), .rst(rst), .en(vld[0]),
    .a(s1.dcr), .b(SIN), .p(pxb)
  );

  skin_mult_pipe #(.AW(D_W), .BW(K_W)) u_pya (
    .clk(clk), .rst(rst), .en(vld[0]),
    .a(s1.dcb), .b(NSIN), .p(pya)
  );

  skin_mult_pipe #(.AW(D_W), .BW(K_W)) u_pyb (
    .clk(clk), .rst(rst), .en(vld[0]),
    .a(s1.dcr), .b(COS), .p(pyb)
  );

  assign sx = S3_W'(pxa) + S3_W'(pxb);
  assign sy = S3_W'(pya) + S3_W'(pyb);

  // S3: back to Q6, then centre on the ellipse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3 <= '0;
    end else if (vld[1]) begin
      s3.ex <= E_W'((sx >>> Q_SH) - ECX);
      s3.ey <= E_W'((sy >>> Q_SH) - ECY);
    end
  end

  // S4: squares
  skin_mult_pipe #(.AW(E_W), .BW(E_W)) u_ex2 (
    .clk(clk), .rst(rst), .en(vld[2]),
    .a(s3.ex), .b(s3.ex), .p(ex2)
  );

  skin_mult_pipe #(.AW(E_W), .BW(E_W)) u_ey2 (
    .clk(clk), .rst(rst), .en(vld[2]),
    .a(s3.ey), .b(s3.ey), .p(ey2)
  );

  // S5: squares are non-negative; zero-extend before signed multiply
  skin_mult_pipe #(.AW(T5A_W), .BW(K_W)) u_ta (
    .clk(clk), .rst(rst), .en(vld[3]),
    .a($signed({1'b0, ex2})), .b(IA2), .p(ta)
  );

  skin_mult_pipe #(.AW(T5A_W), .BW(K_W)) u_tb (
    .clk(clk), .rst(rst), .en(vld[3]),
    .a($signed({1'b0, ey2})), .b(IB2), .p(tb)
  );

  assign tsum = SUM_W'(ta) + SUM_W'(tb);

  // S6: inside-or-on the unit ellipse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skin_out <= 1'b0;
    end else if (vld[4]) begin
      skin_out <= (tsum <= ONE_Q32);
    end
  end

  always_comb begin
    pix_nx  = pix_cnt;
    skin_nx = skin_cnt;
    if (sof_p[LATENCY-1]) begin
      pix_nx  = CNT_W'(1);
      skin_nx = CNT_W'(skin_out);
    end else begin
      if (pix_cnt != CMAX) begin
        pix_nx = pix_cnt + CNT_W'(1);
      end
      if (skin_out && (skin_cnt != CMAX)) begin
        skin_nx = skin_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt     <= '0;
      skin_cnt    <= '0;
      frame_pix   <= '0;
      frame_skin  <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (out_valid) begin
        pix_cnt  <= pix_nx;
        skin_cnt <= skin_nx;
        if (eof_p[LATENCY-1]) begin
          frame_pix   <= pix_nx;
          frame_skin  <= skin_nx;
          stats_valid <= 1'b1;
        end
      end
    end
  end

endmodule
